// File: rtl/g76_video_pkg.sv
// Shared types and defaults for the display-side video fetch path.
package g76_video_pkg;

    localparam int VIDEO_ADDR_W = 17;
    localparam logic [VIDEO_ADDR_W-1:0] DEFAULT_BASE_ADDRESS = 17'h00000;
    localparam int DEFAULT_FRAME_BYTES = 76800;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/video_fetcher_byte_fifo.sv
// Synchronous byte FIFO with flush; pointers carry one extra MSB so full and empty differ.
module byte_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [7:0]                    pushData,
    output logic [7:0]                    headData,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic        writeEn;
    logic        readEn;

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign level    = wrPtr - rdPtr;
    assign headData = mem[rdPtr[AW-1:0]];

    // A push into a full FIFO is legal only when a pop frees the head slot in the same cycle.
    assign readEn  = pop && !empty && !flush;
    assign writeEn = push && (!full || readEn) && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update using pre-edge values.
            if (writeEn) wrPtr <= wrPtr + 1'b1;
            if (readEn)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is governed by the pointers alone.
    always_ff @(posedge clock) begin
        if (writeEn) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/video_fetcher.sv
// Frame fetch sequencer: aims the arbiter's video reads, buffers returned bytes, serves the serializer.
module video_fetcher
    import g76_video_pkg::*;
#(
    parameter logic [VIDEO_ADDR_W-1:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
    parameter int                      FRAME_BYTES  = DEFAULT_FRAME_BYTES,
    parameter int                      FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frameStart,
    input  logic [7:0]                    videoData,
    input  logic                          videoDataReady,
    output logic [VIDEO_ADDR_W-1:0]       videoAddress,
    input  logic                          pixelRequest,
    output logic [7:0]                    pixelData,
    output logic                          pixelValid,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic                          underflow
);

    fetch_state_t            state;
    fetch_state_t            stateNext;
    logic [VIDEO_ADDR_W-1:0] byteCount;
    logic                    discardPending;
    logic                    pushByte;
    logic                    clearDiscard;
    logic                    lastByte;
    logic                    popByte;
    logic                    emptyPop;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic [7:0]              fifoHead;

    assign lastByte = (byteCount == VIDEO_ADDR_W'(FRAME_BYTES - 1));
    // A flush in the same cycle turns any request into an empty pop.
    assign popByte  = pixelRequest && !frameStart && !fifoEmpty;
    assign emptyPop = pixelRequest && !frameStart && fifoEmpty;

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (pushByte),
        .pop      (popByte),
        .flush    (frameStart),
        .pushData (videoData),
        .headData (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .level    (fifoLevel)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        pushByte     = 1'b0;
        clearDiscard = 1'b0;
        if (frameStart) begin
            stateNext = ACTIVE;
        end else if (state == ACTIVE && videoDataReady) begin
            // The first slot after a restart may have sampled a stale address.
            if (discardPending) begin
                clearDiscard = 1'b1;
            end else if (!fifoFull || popByte) begin
                pushByte = 1'b1;
                if (lastByte) stateNext = DONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            videoAddress   <= BASE_ADDRESS;
            byteCount      <= '0;
            discardPending <= 1'b0;
            underflow      <= 1'b0;
        end else if (frameStart) begin
            videoAddress   <= BASE_ADDRESS;
            byteCount      <= '0;
            discardPending <= 1'b1;
            underflow      <= 1'b0;
        end else begin
            if (clearDiscard) discardPending <= 1'b0;
            // Re-aim at the frame base after the last byte so the next frame's first slot is ready.
            if (pushByte) begin
                if (lastByte) begin
                    videoAddress <= BASE_ADDRESS;
                    byteCount    <= '0;
                end else begin
                    videoAddress <= videoAddress + VIDEO_ADDR_W'(1);
                    byteCount    <= byteCount + VIDEO_ADDR_W'(1);
                end
            end
            if (emptyPop) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixelData  <= 8'h00;
            pixelValid <= 1'b0;
        end else if (popByte) begin
            pixelData  <= fifoHead;
            pixelValid <= 1'b1;
        end else if (pixelRequest) begin
            pixelData  <= 8'h00;
            pixelValid <= 1'b0;
        end else begin
            pixelValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_fetcher.sv
// Directed bench for video_fetcher: frame start, discard, back-pressure, end of frame, underflow.
module tb_video_fetcher;

    logic        clock;
    logic        reset;
    logic        frameStart;
    logic [7:0]  videoData;
    logic        videoDataReady;
    logic [16:0] videoAddress;
    logic        pixelRequest;
    logic [7:0]  pixelData;
    logic        pixelValid;
    logic [3:0]  fifoLevel;
    logic        underflow;

    int vectorCount = 0;
    int missCount   = 0;

    video_fetcher #(
        .BASE_ADDRESS (17'h00000),
        .FRAME_BYTES  (16),
        .FIFO_DEPTH   (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .frameStart     (frameStart),
        .videoData      (videoData),
        .videoDataReady (videoDataReady),
        .videoAddress   (videoAddress),
        .pixelRequest   (pixelRequest),
        .pixelData      (pixelData),
        .pixelValid     (pixelValid),
        .fifoLevel      (fifoLevel),
        .underflow      (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One arbiter slot: ready for a cycle, then three quiet cycles.
    task automatic sendByte(input logic [7:0] data);
        videoData      = data;
        videoDataReady = 1'b1;
        tick();
        videoDataReady = 1'b0;
        repeat (3) tick();
    endtask

    task automatic startFrame();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic popByte();
        pixelRequest = 1'b1;
        tick();
        pixelRequest = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        frameStart     = 1'b0;
        videoData      = 8'h00;
        videoDataReady = 1'b0;
        pixelRequest   = 1'b0;

        #2;
        check("rst_addr",  videoAddress, 17'h0);
        check("rst_level", fifoLevel,    4'd0);
        check("rst_data",  pixelData,    8'h00);
        check("rst_valid", pixelValid,   1'b0);
        check("rst_uflow", underflow,    1'b0);
        #10 reset = 1'b1;
        tick();

        repeat (3) sendByte(8'hEE);
        check("idle_level", fifoLevel,    4'd0);
        check("idle_addr",  videoAddress, 17'd0);

        startFrame();
        check("fs_addr",  videoAddress, 17'd0);
        sendByte(8'h10);
        check("discard_addr", videoAddress, 17'd0);
        sendByte(8'h11);
        sendByte(8'h12);
        check("fs_level", fifoLevel,    4'd2);
        check("fs_addr2", videoAddress, 17'd2);

        popByte();
        check("pop1_data",  pixelData,  8'h11);
        check("pop1_valid", pixelValid, 1'b1);
        tick();
        check("idle_valid", pixelValid, 1'b0);
        check("hold_data",  pixelData,  8'h11);
        popByte();
        check("pop2_data",  pixelData,  8'h12);
        check("pop2_valid", pixelValid, 1'b1);
        check("pop2_level", fifoLevel,  4'd0);

        popByte();
        check("uf_data",  pixelData,  8'h00);
        check("uf_valid", pixelValid, 1'b0);
        check("uf_flag",  underflow,  1'b1);
        sendByte(8'h20);
        check("uf_addr", videoAddress, 17'd3);
        popByte();
        check("uf_pop_data",  pixelData,  8'h20);
        check("uf_pop_valid", pixelValid, 1'b1);
        check("uf_sticky",    underflow,  1'b1);

        startFrame();
        check("uf_clear", underflow,    1'b0);
        check("rs_addr",  videoAddress, 17'd0);
        for (int i = 0; i < 12; i++) sendByte(8'h30 + 8'(i));
        check("bp_level", fifoLevel,    4'd8);
        check("bp_addr",  videoAddress, 17'd8);
        popByte();
        check("bp_pop",       pixelData, 8'h31);
        check("bp_pop_level", fifoLevel, 4'd7);
        sendByte(8'hAB);
        check("bp_ab_level", fifoLevel,    4'd8);
        check("bp_ab_addr",  videoAddress, 17'd9);
        for (int i = 2; i <= 8; i++) begin
            popByte();
            check("bp_drain", pixelData, 8'h30 + 8'(i));
        end
        popByte();
        check("bp_drain_ab",  pixelData, 8'hAB);
        check("bp_drained",   fifoLevel, 4'd0);

        for (int i = 0; i < 6; i++) sendByte(8'h60 + 8'(i));
        check("eof_level15", fifoLevel,    4'd6);
        check("eof_addr15",  videoAddress, 17'd15);
        sendByte(8'h66);
        check("eof_level", fifoLevel,    4'd7);
        check("eof_addr",  videoAddress, 17'd0);
        repeat (2) sendByte(8'h99);
        check("done_level", fifoLevel,    4'd7);
        check("done_addr",  videoAddress, 17'd0);

        frameStart     = 1'b1;
        videoDataReady = 1'b1;
        videoData      = 8'h41;
        tick();
        frameStart     = 1'b0;
        videoDataReady = 1'b0;
        check("fsr_flush", fifoLevel,    4'd0);
        check("fsr_addr",  videoAddress, 17'd0);
        repeat (3) tick();
        sendByte(8'h42);
        check("fsr_drop_level", fifoLevel,    4'd0);
        check("fsr_drop_addr",  videoAddress, 17'd0);
        for (int i = 0; i < 8; i++) sendByte(8'h50 + 8'(i));
        check("re_level", fifoLevel,    4'd8);
        check("re_addr",  videoAddress, 17'd8);

        frameStart   = 1'b1;
        pixelRequest = 1'b1;
        tick();
        frameStart   = 1'b0;
        pixelRequest = 1'b0;
        check("fsp_level", fifoLevel,  4'd0);
        check("fsp_valid", pixelValid, 1'b0);
        check("fsp_data",  pixelData,  8'h00);
        check("fsp_uflow", underflow,  1'b0);
        check("fsp_addr",  videoAddress, 17'd0);

        sendByte(8'h70);
        sendByte(8'h77);
        check("pre_rst_level", fifoLevel,    4'd1);
        check("pre_rst_addr",  videoAddress, 17'd1);
        popByte();
        check("pre_rst_data", pixelData, 8'h77);

        #3 reset = 1'b0;
        #1;
        check("mid_rst_addr",  videoAddress, 17'd0);
        check("mid_rst_valid", pixelValid,   1'b0);
        check("mid_rst_data",  pixelData,    8'h00);
        check("mid_rst_level", fifoLevel,    4'd0);
        check("mid_rst_uflow", underflow,    1'b0);
        #3 reset = 1'b1;
        tick();
        sendByte(8'h88);
        check("post_rst_level", fifoLevel,    4'd0);
        check("post_rst_addr",  videoAddress, 17'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/video_fetcher.md
# video_fetcher

Display-side fetch stage that sits directly downstream of the SRAM arbiter's video port. It drives the 17-bit video read address and captures each byte returned by the arbiter's per-slot `videoDataReady` pulse into a small FIFO. It serves those bytes to the pixel serializer on demand, so the display path is decoupled from the arbiter's fixed 4-cycle slot schedule. Frame sequencing, back-pressure (re-reading when full) and underflow detection are owned here.

## Interface
- `BASE_ADDRESS`, 17'h00000, first framebuffer byte address
- `FRAME_BYTES`, 76800, bytes per frame (320×240 at 8 bpp); legal range 1 to 2^17 − BASE_ADDRESS
- `FIFO_DEPTH`, 8, FIFO entries; power of two, ≥2
- `clock` in 1: sole clock, all logic on posedge
- `reset` in 1: asynchronous, active-low
- `frameStart` in 1: single-cycle pulse from the video timing generator at the start of frame fetch
- `videoData` in 8: byte from the arbiter, valid while `videoDataReady`=1
- `videoDataReady` in 1: arbiter slot-complete pulse, at most 1 cycle in every 4
- `videoAddress` out 17: address the arbiter reads in its next video slot
- `pixelRequest` in 1: serializer pops one byte this cycle
- `pixelData` out 8: popped byte, registered
- `pixelValid` out 1: `pixelData` holds a byte popped on the previous cycle
- `fifoLevel` out $clog2(FIFO_DEPTH)+1: current occupancy
- `underflow` out 1: sticky flag, set on a pop from an empty FIFO, cleared by `frameStart`

## Operation
- States:
  - IDLE: after reset; no pushes; waits for `frameStart`.
  - ACTIVE: fetching.
  - DONE: all FRAME_BYTES pushed; ignores `videoDataReady`.
- Transitions:
  - IDLE→ACTIVE on `frameStart`.
  - ACTIVE→DONE on the push of byte FRAME_BYTES−1.
  - Any state→ACTIVE on `frameStart`, including ACTIVE itself (restart).
- On `frameStart`:
  - Flush the FIFO (level 0).
  - Set `videoAddress`=BASE_ADDRESS and the byte counter to 0.
  - Clear `underflow`.
  - Set the discard flag.
- Discard flag: the first `videoDataReady` strictly after `frameStart` is dropped, because that slot's address may have been sampled before the update. The drop clears the flag and leaves the address unchanged. A `videoDataReady` in the same cycle as `frameStart` is also dropped, and does not clear the flag.
- `videoDataReady` in ACTIVE, discard flag clear:
  - FIFO not full: push `videoData`; increment `videoAddress` and the counter.
  - FIFO full: drop the byte; hold `videoAddress`. The arbiter re-reads the same address next slot.
- In DONE, `videoAddress` is held at BASE_ADDRESS so the next frame's first slot is already aimed.
- `videoAddress` never exceeds BASE_ADDRESS+FRAME_BYTES−1; no wrap inside a frame.
- `pixelRequest` with FIFO non-empty: pop; `pixelData`←head and `pixelValid`←1 next cycle.
- `pixelRequest` with FIFO empty: `pixelData`←8'h00, `pixelValid`←0, `underflow`←1.
- No request: `pixelValid`←0; `pixelData` holds its last value.
- Push and pop in the same cycle:
  - FIFO full: both occur, level unchanged.
  - FIFO empty: underflow; there is no bypass path.
- `frameStart` coinciding with `pixelRequest`: the flush wins; treat the pop as an empty pop, but `underflow` stays 0.

## Timing
- Reset values (asserted asynchronously):
  - state IDLE
  - `videoAddress`=BASE_ADDRESS
  - `pixelData`=0, `pixelValid`=0
  - `fifoLevel`=0
  - `underflow`=0
  - discard flag 0
- `videoAddress` updates on the posedge after the accepting `videoDataReady`. It is stable ≥3 cycles before the arbiter's next address sample.
- Pop latency is 1 cycle (`pixelRequest` at N → `pixelValid` at N+1).
- `fifoLevel` reflects pushes/pops at the next posedge.
- Sustained throughput is ≤1 byte per 4 clocks; the serializer must average no faster.
- Reset deasserted mid-frame: stays IDLE until the next `frameStart`; no spurious pushes.

## Structure
- Package `g76_video_pkg`:
  - `VIDEO_ADDR_W`=17
  - default FRAME_BYTES/BASE_ADDRESS
  - `fetch_state_t` enum {IDLE, ACTIVE, DONE}
- Sub-module `byte_fifo`: synchronous FIFO of `FIFO_DEPTH`×8 with push/pop/flush, full/empty and level outputs. Pointers are $clog2(FIFO_DEPTH)+1 bits wide, with the extra MSB distinguishing full from empty.
- `video_fetcher` holds the FSM, address/counter, discard flag and pop/underflow logic.

## Test plan
- Reset:
  - Assert `reset`=0 mid-cycle → all outputs at reset values immediately.
  - `videoDataReady` pulses while IDLE → `fifoLevel` stays 0 and `videoAddress` stays 0.
- Frame start:
  - `frameStart`, then ready pulses every 4 cycles carrying 0x10, 0x11, 0x12 → 0x10 is discarded; level 2; `videoAddress`=2.
  - Popping then yields 0x11, 0x12 with `pixelValid` one cycle later.
- Back-pressure: FIFO_DEPTH=8, no pops, 11 pulses after the discard → level 8; `videoAddress`=8 and held.
  - One pop, then a pulse with 0xAB → 0xAB is pushed; address becomes 9.
- End of frame: FRAME_BYTES=16 → after 16 pushes, state DONE and `videoAddress`=0.
  - Further pulses are ignored.
  - A new `frameStart` restarts fetch from address 0.
- Underflow: pop from an empty FIFO → next cycle `pixelData`=0, `pixelValid`=0, `underflow`=1.
  - `underflow` persists through later valid pops and clears on `frameStart`.
- Simultaneous events:
  - `frameStart` together with `videoDataReady` → byte dropped and the next pulse also dropped.
  - `frameStart` with a full FIFO → level 0 next cycle.
